// File: rtl/wordle_input_conditioner.sv
// wordle_input_conditioner: synchronise/debounce ENTER, CLEAR and letter switches, emit pulses and a decoded letter
// Ports: clk, reset (async, active high); key_enter_n/key_clear_n raw active-low buttons;
//   switch_raw[9:3] one-hot slot ([9] = slot 0), [2:0] bank code; enter_pulse/clear_pulse one-cycle
//   confirmations; letter_code (0..25, 31 when invalid) and letter_valid decoded from switch_stable.
// Build option WORDLE_REJECT_INVALID_EN: adds reject_pulse, which replaces enter_pulse when the letter is invalid.

module wordle_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic fire_o
);
  typedef enum logic [2:0] {LOCKED, IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pressed, last;
  assign pressed = ~sync_q[1];
  assign last = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= 2'b11;
      state_q <= LOCKED;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // The counter only ever runs in the waiting states; every other transition clears it.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      LOCKED:
        if (!pressed) begin
          state_d = last ? IDLE : LOCKED;
          cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
      IDLE: if (pressed) state_d = PRESS_WAIT;
      PRESS_WAIT:
        if (!pressed) state_d = IDLE;
        else if (last) state_d = PRESSED;
        else cnt_d = cnt_q + CNT_W'(1);
      PRESSED: if (!pressed) state_d = RELEASE_WAIT;
      RELEASE_WAIT:
        if (pressed) state_d = PRESSED;
        else if (last) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = LOCKED;
    endcase
  end
  always_comb fire_o = state_q == PRESS_WAIT && pressed && last;
endmodule

module wordle_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_enter_n,
  input  logic       key_clear_n,
  input  logic [9:0] switch_raw,
  output logic       enter_pulse,
  output logic       clear_pulse,
  output logic [4:0] letter_code,
  output logic       letter_valid,
`ifdef WORDLE_REJECT_INVALID_EN
  output logic       reject_pulse,
`endif
  output logic [9:0] switch_stable
);
  logic enter_fire, clear_fire;
  logic [9:0] sw_s1_q, sw_s2_q, cand_q, stable_q, stable_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic sw_diff, sw_last, sw_load;
  logic [4:0] code_q, code_d, sum;
  logic valid_q, valid_d, one_hot, bank_ok;
  logic [6:0] slots;
  logic [2:0] bank_raw, slot;
  logic [1:0] bank;
  logic enter_q, clear_q, pend_q, enter_req, enter_go, pend_d, enter_d;
`ifdef WORDLE_REJECT_INVALID_EN
  logic reject_q, reject_d;
`endif

  wordle_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clk(clk), .reset(reset), .key_n_i(key_enter_n), .fire_o(enter_fire)
  );
  wordle_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clk(clk), .reset(reset), .key_n_i(key_clear_n), .fire_o(clear_fire)
  );

  // The candidate always follows the synced vector; the counter saturates, and a load only
  // happens when it actually changes switch_stable, so two loads are never back to back.
  assign sw_diff = sw_s2_q != cand_q;
  assign sw_last = sw_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign sw_load = !sw_diff && sw_last && cand_q != stable_q;
  assign sw_cnt_d = sw_diff ? '0 : sw_last ? sw_cnt_q : sw_cnt_q + CNT_W'(1);
  assign stable_d = sw_load ? cand_q : stable_q;

  always_comb begin
    slots = stable_q[9:3];
    bank_raw = stable_q[2:0];
    slot = '0;
    for (int i = 0; i < 7; i++) if (slots[i]) slot = 3'(6 - i);
    one_hot = slots != '0 && (slots & (slots - 7'd1)) == '0;
    bank_ok = bank_raw inside {3'b000, 3'b001, 3'b010, 3'b100};
    bank = bank_raw[2] ? 2'd3 : bank_raw[1] ? 2'd2 : {1'b0, bank_raw[0]};
    sum = 5'(bank) * 5'd7 + 5'(slot);
    valid_d = one_hot && bank_ok && sum <= 5'd25;
    code_d = valid_d ? sum : 5'd31;
  end

  // CLEAR wins a tie and kills the ENTER request (including a deferred one); an ENTER that
  // lands on a switch_stable update is held back by one cycle.
  assign enter_req = (enter_fire | pend_q) & ~clear_fire;
  assign enter_go = enter_req & ~sw_load;
  assign pend_d = enter_req & sw_load;
`ifdef WORDLE_REJECT_INVALID_EN
  // valid_d is the letter_valid shown during the cycle the pulse is visible.
  assign enter_d = enter_go & valid_d;
  assign reject_d = enter_go & ~valid_d;
`else
  assign enter_d = enter_go;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      cand_q <= '0;
      sw_cnt_q <= '0;
      stable_q <= '0;
      code_q <= 5'd31;
      valid_q <= 1'b0;
      enter_q <= 1'b0;
      clear_q <= 1'b0;
      pend_q <= 1'b0;
`ifdef WORDLE_REJECT_INVALID_EN
      reject_q <= 1'b0;
`endif
    end else begin
      sw_s1_q <= switch_raw;
      sw_s2_q <= sw_s1_q;
      cand_q <= sw_s2_q;
      sw_cnt_q <= sw_cnt_d;
      stable_q <= stable_d;
      code_q <= code_d;
      valid_q <= valid_d;
      enter_q <= enter_d;
      clear_q <= clear_fire;
      pend_q <= pend_d;
`ifdef WORDLE_REJECT_INVALID_EN
      reject_q <= reject_d;
`endif
    end

  assign enter_pulse = enter_q;
  assign clear_pulse = clear_q;
  assign letter_code = code_q;
  assign letter_valid = valid_q;
  assign switch_stable = stable_q;
`ifdef WORDLE_REJECT_INVALID_EN
  assign reject_pulse = reject_q;
`endif
endmodule

// File: tb/tb_wordle_input_conditioner.sv
// tb_wordle_input_conditioner: vector table, directed key sequences and randomized switch checks
module tb_wordle_input_conditioner;
  localparam int D = 4;
  typedef struct {
    logic [9:0] sw;
    logic [4:0] code;
    logic       valid;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, key_enter_n = 1'b1, key_clear_n = 1'b1;
  logic [9:0] switch_raw = '0;
  logic enter_pulse, clear_pulse, letter_valid;
  logic [4:0] letter_code;
  logic [9:0] switch_stable;
`ifdef WORDLE_REJECT_INVALID_EN
  logic reject_pulse;
`endif

  int tests = 0, fails = 0, cyc = 0;
  int en_cnt, cl_cnt, rj_cnt, en_first, sw_first, c0;
  logic [9:0] sw_watch = '0;
  vec_t vecs[10];
  logic [9:0] hist[$];
  logic [9:0] st_m, new_st, x;
  logic [5:0] exp_l;
  logic eq;
  int s, b, n;

  wordle_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .key_enter_n(key_enter_n), .key_clear_n(key_clear_n),
    .switch_raw(switch_raw), .enter_pulse(enter_pulse), .clear_pulse(clear_pulse),
    .letter_code(letter_code), .letter_valid(letter_valid),
`ifdef WORDLE_REJECT_INVALID_EN
    .reject_pulse(reject_pulse),
`endif
    .switch_stable(switch_stable)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (enter_pulse === 1'b1) begin
      en_cnt++;
      if (en_first < 0) en_first = cyc;
    end
    if (clear_pulse === 1'b1) cl_cnt++;
`ifdef WORDLE_REJECT_INVALID_EN
    if (reject_pulse === 1'b1) rj_cnt++;
`endif
    if (sw_first < 0 && switch_stable === sw_watch) sw_first = cyc;
  endtask

  task automatic clr();
    en_cnt = 0; cl_cnt = 0; rj_cnt = 0; en_first = -1; sw_first = -1;
  endtask

  task automatic hold(input logic e, input logic c, input int k);
    key_enter_n = e;
    key_clear_n = c;
    repeat (k) step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_enter"}, enter_pulse, 0);
    check({tag, "_clear"}, clear_pulse, 0);
    check({tag, "_code"}, letter_code, 31);
    check({tag, "_valid"}, letter_valid, 0);
    check({tag, "_stable"}, switch_stable, 0);
  endtask

  function automatic logic [5:0] ref_letter(input logic [9:0] sw);
    int slot, bank, code;
    slot = 0;
    for (int i = 0; i < 7; i++) if (sw[9-i]) slot = i;
    case (sw[2:0])
      3'b000: bank = 0;
      3'b001: bank = 1;
      3'b010: bank = 2;
      3'b100: bank = 3;
      default: bank = -1;
    endcase
    code = bank * 7 + slot;
    if ($countones(sw[9:3]) == 1 && bank >= 0 && code <= 25) return {1'b1, 5'(code)};
    return {1'b0, 5'd31};
  endfunction

  initial begin
    vecs[0] = '{10'b0100000010, 5'd15, 1'b1};
    vecs[1] = '{10'b0000010100, 5'd31, 1'b0};
    vecs[2] = '{10'b1100000000, 5'd31, 1'b0};
    vecs[3] = '{10'b0000001001, 5'd13, 1'b1};
    vecs[4] = '{10'b1000000000, 5'd0,  1'b1};
    vecs[5] = '{10'b0000100100, 5'd25, 1'b1};
    vecs[6] = '{10'b0000001011, 5'd31, 1'b0};
    vecs[7] = '{10'b0000000000, 5'd31, 1'b0};
    vecs[8] = '{10'b0000001000, 5'd6,  1'b1};
    vecs[9] = '{10'b0010000100, 5'd23, 1'b1};
    clr();

    // ENTER held through reset never pulses
    key_enter_n = 1'b0;
    repeat (3) step();
    check_reset_state("reset");
    reset = 1'b0;
    hold(0, 1, 10);
    check("held_through_reset", en_cnt, 0);
    hold(1, 1, 6);
    // press is sampled on the next edge; the pulse follows D+2 edges after that
    clr(); c0 = cyc;
    hold(0, 1, 10);
    check("first_press_count", en_cnt, 1);
    check("first_press_latency", en_first - c0, D + 3);
    hold(1, 1, 12);

    // bounce 1-0-1-0 every 2 cycles, then steady pressed
    clr();
    hold(1, 1, 2);
    hold(0, 1, 2);
    hold(1, 1, 2);
    c0 = cyc;
    hold(0, 1, 12);
    check("bounce_count", en_cnt, 1);
    check("bounce_latency", en_first - c0, D + 3);
    hold(1, 1, 12);

    // letter decode table: held 8 cycles each
    foreach (vecs[i]) begin
      switch_raw = vecs[i].sw;
      repeat (8) step();
      check($sformatf("vec%0d_code", i), letter_code, vecs[i].code);
      check($sformatf("vec%0d_valid", i), letter_valid, vecs[i].valid);
      check($sformatf("vec%0d_stable", i), switch_stable, vecs[i].sw);
    end

    // both keys on the same cycle: CLEAR wins
    switch_raw = '0;
    hold(1, 1, 12);
    clr();
    hold(0, 0, 12);
    check("both_clear", cl_cnt, 1);
    check("both_enter", en_cnt, 0);
    hold(1, 1, 12);

    // ENTER with no valid letter
    check("invalid_letter_valid", letter_valid, 0);
    clr();
    hold(0, 1, 12);
`ifdef WORDLE_REJECT_INVALID_EN
    check("invalid_reject", rj_cnt, 1);
    check("invalid_enter", en_cnt, 0);
`else
    check("invalid_enter", en_cnt, 1);
`endif
    hold(1, 1, 12);

    // ENTER confirmation coinciding with a switch_stable update is pushed back one cycle
    sw_watch = 10'b1000000000;
    clr();
    switch_raw = sw_watch;
    c0 = cyc;
    hold(0, 1, 12);
    check("coincide_stable_latency", sw_first - c0, D + 3);
    check("coincide_enter_latency", en_first - c0, D + 4);
    check("coincide_enter_count", en_cnt, 1);
    hold(1, 1, 12);

    // reset in the middle of a press debounce
    clr();
    hold(0, 1, 4);
    reset = 1'b1;
    repeat (2) step();
    check_reset_state("midreset");
    reset = 1'b0;
    hold(0, 1, 12);
    hold(1, 1, 12);
    check("midreset_no_pulse", en_cnt, 0);

    // randomized switches against a windowed-equality model: switch_stable takes a value once
    // the sampled raw vector has held it for D+1 consecutive edges, delayed by the 2 sync stages
    switch_raw = '0;
    hold(1, 1, 12);
    clr();
    hist.delete();
    repeat (D + 2) hist.push_back('0);
    st_m = '0;
    x = '0;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) x = 10'($urandom);
        else begin
          s = $urandom_range(0, 6);
          b = $urandom_range(0, 3);
          x[9:3] = 7'b1000000 >> s;
          x[2:0] = (b == 0) ? 3'b000 : 3'(1 << (b - 1));
        end
      end
      switch_raw = x;
      step();
      hist.push_back(x);
      n = hist.size();
      eq = 1'b1;
      for (int j = n - 3 - D; j <= n - 3; j++) if (hist[j] != hist[n-3]) eq = 1'b0;
      new_st = eq ? hist[n-3] : st_m;
      exp_l = ref_letter(st_m);
      st_m = new_st;
      check("rand_stable", switch_stable, st_m);
      check("rand_code", letter_code, exp_l[4:0]);
      check("rand_valid", letter_valid, exp_l[5]);
      void'(hist.pop_front());
    end
    check("rand_no_enter", en_cnt, 0);
    check("rand_no_clear", cl_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
